// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and round-robin pick helper for fifo_wr_arbiter
// Contents: arb_state_e (IDLE/BURST), WW_WIDTH (words_written width),
//           rr_pick(req, ptr, n) -> first set index of req searching upward from ptr+1 mod n.
package fifo_arb_pkg;

  localparam int WW_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // req/ptr are zero-extended to the 8-producer maximum; n is the live producer count.
  // Offsets are scanned from farthest to nearest so the nearest set request wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [3:0] k;
    logic [2:0] res;
    res = '0;
    for (int i = 8; i >= 1; i--) begin
      k = {1'b0, ptr} + 4'(i);
      // ptr < n and i <= n, so one subtraction is a full modulo
      if (k >= n) k = k - n;
      if ((4'(i) <= n) && req[k[2:0]]) res = k[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer and FIFO write-port signals of fifo_wr_arbiter
// Producer side: req_valid/req_data/req_last in, req_ready out (per producer).
// FIFO side: fifo_wr_en/fifo_data_in out, fifo_full/fifo_wr_ack/fifo_overflow in.
// slave = the arbiter, master = the environment (producers plus FIFO).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/rr_arbiter_core.sv
// rtl/rr_arbiter_core.sv - combinational round-robin priority pick
// Ports: req (request vector), ptr (last winner) in; idx (winner), any (some request set) out.
module rr_arbiter_core
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [7:0] req_ext;
  logic [2:0] ptr_ext;
  logic [2:0] pick;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    ptr_ext = '0;
    ptr_ext[IDX_W-1:0] = ptr;
  end

  assign pick = rr_pick(req_ext, ptr_ext, 4'(NUM_REQ));
  assign idx  = pick[IDX_W-1:0];
  assign any  = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst round-robin arbiter sharing one FIFO write port
// Ports: clk, rst (async active-high); bus (fifo_wr_arbiter_if.slave: producers + FIFO);
//        grant_valid/grant_id (active grant), err_overflow/err_ack (sticky errors),
//        words_written (wr_ack count, wraps).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_wr_arbiter_if.slave           bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_overflow,
  output logic                       err_ack,
  output logic [WW_WIDTH-1:0]        words_written
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [7:0]       beat_cnt;
  logic             ack_expected;
  logic             beat;
  logic             burst_end;

  rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign grant_valid = (state == BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_data_in = '0;
    beat             = 1'b0;
    burst_end        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = BURST;
      end
      BURST: begin
        // ready tracks only FIFO space, so a full FIFO stalls the beat and the write together
        bus.req_ready[grant_id] = !bus.fifo_full;
        beat = bus.req_valid[grant_id] & !bus.fifo_full;
        bus.fifo_wr_en = beat;
        if (beat) bus.fifo_data_in = bus.req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
        // last and burst limit may coincide; either ends the same single burst
        burst_end = beat & (bus.req_last[grant_id] | (beat_cnt == 8'(MAX_BURST - 1)));
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id      <= '0;
      rr_ptr        <= IDX_W'(NUM_REQ - 1);
      beat_cnt      <= '0;
      err_overflow  <= 1'b0;
      err_ack       <= 1'b0;
      words_written <= '0;
      ack_expected  <= 1'b0;
    end else begin
      ack_expected <= bus.fifo_wr_en;
      if (state == IDLE && pick_any) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end else if (burst_end) begin
        rr_ptr   <= grant_id;
        grant_id <= '0;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (bus.fifo_overflow) err_overflow <= 1'b1;
      // an overflow cycle carries no ack, so the ack comparison is skipped there
      if (!bus.fifo_overflow && (bus.fifo_wr_ack != ack_expected)) err_ack <= 1'b1;
      if (bus.fifo_wr_ack) words_written <= words_written + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err_overflow;
  logic        err_ack;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .err_overflow  (err_overflow),
    .err_ack       (err_ack),
    .words_written (words_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // producer model: each producer sends cnt_left words, data = {id, 4'h0, seq}
  logic       load;
  logic [7:0] ld_cnt [4];
  logic [3:0] ld_last;
  logic [3:0] hold;
  logic [7:0] cnt_left [4];
  logic [7:0] sent [4];
  logic [3:0] use_last;

  // write log
  logic [3:0] log_id [32];
  logic [1:0] log_gid [32];
  int         log_cyc [32];
  int         log_n;
  int         cyc = 0;

  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = (cnt_left[i] != 0) && !hold[i];
      bus.req_last[i]  = use_last[i] && (cnt_left[i] == 8'd1);
      bus.req_data[i*16 +: 16] = {4'(i), 4'h0, sent[i]};
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < 4; i++) begin
        cnt_left[i] <= ld_cnt[i];
        sent[i]     <= 8'd0;
      end
      use_last <= ld_last;
      log_n    <= 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          cnt_left[i] <= cnt_left[i] - 8'd1;
          sent[i]     <= sent[i] + 8'd1;
        end
      if (bus.fifo_wr_en && log_n < 32) begin
        log_id[log_n]  <= bus.fifo_data_in[15:12];
        log_gid[log_n] <= grant_id;
        log_cyc[log_n] <= cyc;
        log_n          <= log_n + 1;
      end
    end
  end

  // FIFO model, depth 8
  int   fcnt;
  logic f_ld;
  int   f_ld_val;
  logic rd_en, force_ovf, suppress_ack, ack_q, ovf_q;

  assign bus.fifo_full     = (fcnt == 8);
  assign bus.fifo_wr_ack   = ack_q;
  assign bus.fifo_overflow = ovf_q | force_ovf;

  always @(posedge clk) begin
    if (f_ld) fcnt <= f_ld_val;
    else fcnt <= fcnt + ((bus.fifo_wr_en && !bus.fifo_full) ? 1 : 0)
                      - ((rd_en && fcnt > 0) ? 1 : 0);
    ack_q <= bus.fifo_wr_en && !bus.fifo_full && !suppress_ack;
    ovf_q <= bus.fifo_wr_en && bus.fifo_full;
  end

  // called at a negedge; returns at the next negedge with the new counts loaded
  task automatic start_prod(input logic [7:0] c0, c1, c2, c3, input logic [3:0] lm);
    ld_cnt[0] = c0; ld_cnt[1] = c1; ld_cnt[2] = c2; ld_cnt[3] = c3;
    ld_last = lm;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!(((cnt_left[0] | cnt_left[1] | cnt_left[2] | cnt_left[3]) == 8'd0) && !grant_valid)
           && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(t < 300), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sent(input int p, input int n, input string tag);
    int t;
    t = 0;
    while (sent[p] != 8'(n) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_reach"}, 32'(t < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hold = '0; rd_en = 1'b1; force_ovf = 1'b0; suppress_ack = 1'b0;
    f_ld = 1'b1; f_ld_val = 0;
    ld_cnt[0] = 0; ld_cnt[1] = 0; ld_cnt[2] = 0; ld_cnt[3] = 0; ld_last = '0; load = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gv", 32'(grant_valid), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_wren", 32'(bus.fifo_wr_en), 0);
    check("rst_words", 32'(words_written), 0);
    check("rst_errs", {30'd0, err_overflow, err_ack}, 0);
    rst = 1'b0; load = 1'b0; f_ld = 1'b0;
    @(negedge clk);

    // 1: all four producers, no last -> 0,1,2,3 bursts of 4 with one idle gap
    start_prod(4, 4, 4, 4, 4'b0000);
    wait_idle("t1");
    check("t1_n", 32'(log_n), 16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_id%0d", k), 32'(log_id[k]), 32'(k / 4));
      check($sformatf("t1_cyc%0d", k), 32'(log_cyc[k] - log_cyc[0]), 32'(k + k / 4));
    end
    check("t1_words", 32'(words_written), 16);

    // 2: producer 2 with last on 3rd word; then 0 and 3 together -> 3 first
    start_prod(0, 0, 3, 0, 4'b0100);
    wait_idle("t2a");
    check("t2a_n", 32'(log_n), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2a_id%0d", k), 32'(log_id[k]), 2);
      check($sformatf("t2a_gid%0d", k), 32'(log_gid[k]), 2);
      check($sformatf("t2a_cyc%0d", k), 32'(log_cyc[k] - log_cyc[0]), 32'(k));
    end
    start_prod(2, 0, 0, 2, 4'b1001);
    wait_idle("t2b");
    check("t2b_n", 32'(log_n), 4);
    check("t2b_id0", 32'(log_id[0]), 3);
    check("t2b_id1", 32'(log_id[1]), 3);
    check("t2b_id2", 32'(log_id[2]), 0);
    check("t2b_id3", 32'(log_id[3]), 0);
    check("t2b_gap", 32'(log_cyc[2] - log_cyc[1]), 2);
    check("t2_words", 32'(words_written), 23);

    // 3: FIFO at 7/8, producer 1 sends 4; full stalls, one read frees one slot
    rd_en = 1'b0; f_ld_val = 7; f_ld = 1'b1;
    start_prod(0, 4, 0, 0, 4'b0000);
    f_ld = 1'b0;
    @(negedge clk);
    check("t3_first_wren", 32'(bus.fifo_wr_en), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("t3_stall_rdy%0d", k), 32'(bus.req_ready[1]), 0);
      check($sformatf("t3_stall_wren%0d", k), 32'(bus.fifo_wr_en), 0);
      check($sformatf("t3_stall_gv%0d", k), 32'(grant_valid), 1);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t3_after_read_wren", 32'(bus.fifo_wr_en), 1);
    @(negedge clk);
    check("t3_full_again_wren", 32'(bus.fifo_wr_en), 0);
    check("t3_n2", 32'(log_n), 2);
    rd_en = 1'b1;
    wait_idle("t3");
    check("t3_n", 32'(log_n), 4);
    check("t3_ovf", 32'(err_overflow), 0);
    check("t3_ack", 32'(err_ack), 0);
    check("t3_words", 32'(words_written), 27);

    // 4: producer 3 drops valid for 5 cycles after 2 words; producer 0 waits
    start_prod(1, 0, 0, 4, 4'b0001);
    wait_sent(3, 2, "t4");
    hold[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t4_gid%0d", k), 32'(grant_id), 3);
      check($sformatf("t4_wren%0d", k), 32'(bus.fifo_wr_en), 0);
    end
    hold[3] = 1'b0;
    wait_idle("t4");
    check("t4_n", 32'(log_n), 5);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_id%0d", k), 32'(log_id[k]), 3);
    check("t4_id4", 32'(log_id[4]), 0);
    check("t4_gap", 32'(log_cyc[2] - log_cyc[1]), 6);
    check("t4_words", 32'(words_written), 32);

    // 5: one overflow cycle, then one suppressed ack
    force_ovf = 1'b1;
    @(negedge clk);
    force_ovf = 1'b0;
    check("t5_ovf_set", 32'(err_overflow), 1);
    check("t5_ack_clear", 32'(err_ack), 0);
    suppress_ack = 1'b1;
    start_prod(0, 0, 1, 0, 4'b0100);
    wait_idle("t5");
    suppress_ack = 1'b0;
    check("t5_ack_set", 32'(err_ack), 1);
    check("t5_words", 32'(words_written), 32);
    repeat (3) @(negedge clk);
    check("t5_ovf_sticky", 32'(err_overflow), 1);
    check("t5_ack_sticky", 32'(err_ack), 1);

    // 6: reset in the middle of producer 1's burst, then all producers
    start_prod(0, 4, 0, 0, 4'b0000);
    wait_sent(1, 2, "t6");
    rst = 1'b1;
    #1;
    check("t6_gv", 32'(grant_valid), 0);
    check("t6_gid", 32'(grant_id), 0);
    check("t6_ready", 32'(bus.req_ready), 0);
    check("t6_wren", 32'(bus.fifo_wr_en), 0);
    check("t6_words", 32'(words_written), 0);
    check("t6_errs", {30'd0, err_overflow, err_ack}, 0);
    start_prod(4, 4, 4, 4, 4'b0000);
    rst = 1'b0;
    wait_idle("t6");
    check("t6_n", 32'(log_n), 16);
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_id%0d", k), 32'(log_id[k]), 0);
    check("t6_id4", 32'(log_id[4]), 1);
    check("t6_words_after", 32'(words_written), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
